// File: rtl/sonar_pkg.sv
// Shared types and defaults for the sonar ranging chain (echo timer and
// distance filter).
package sonar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FILTER = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   localparam int RAW_W             = 32;
   localparam int DIST_W            = 16;
   localparam int DEF_CYCLES_PER_CM = 2900;
   localparam int DEF_MAX_CM        = 400;

   function automatic logic [DIST_W-1:0] abs_diff16(input logic [DIST_W-1:0] a,
                                                    input logic [DIST_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sonar_distance_filter_if.sv
// Sample-in / distance-out bundle between the echo timer, the distance
// filter and the navigation logic.
interface sonar_distance_filter_if;
   import sonar_pkg::*;

   logic              raw_valid;
   logic [RAW_W-1:0]  raw_count;
   logic              busy;
   logic              dist_valid;
   logic [DIST_W-1:0] dist_cm;
   logic              out_of_range;
   logic              dropped;

   modport master (
      output raw_valid, raw_count,
      input  busy, dist_valid, dist_cm, out_of_range, dropped
   );

   modport slave (
      input  raw_valid, raw_count,
      output busy, dist_valid, dist_cm, out_of_range, dropped
   );

endinterface

// File: rtl/seq_divider_32x16.sv
// Restoring divider, 32-bit dividend by 16-bit divisor, one quotient bit per
// cycle. The first bit is produced on the start edge; done pulses 32 cycles later.
module seq_divider_32x16 (
   input  logic        clk,
   input  logic        set,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic        done,
   output logic [31:0] quotient
);

   logic [15:0] rem_reg, rem_next;
   logic [31:0] dvd_reg, dvd_next;
   logic [31:0] quo_reg, quo_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic        active_reg, active_next;
   logic        done_reg, done_next;

   logic [15:0] src_rem;
   logic [31:0] src_dvd;
   logic [31:0] src_quo;
   logic [16:0] partial;
   logic [16:0] diff;
   logic        ge;

   // On start the step runs from a cleared remainder and the fresh dividend,
   // so the start edge itself already yields quotient bit 31.
   always_comb begin
      src_rem = start ? 16'd0 : rem_reg;
      src_dvd = start ? dividend : dvd_reg;
      src_quo = start ? 32'd0 : quo_reg;
      partial = {src_rem, src_dvd[31]};
      diff    = partial - {1'b0, divisor};
      ge      = (partial >= {1'b0, divisor});
   end

   always_comb begin
      rem_next    = rem_reg;
      dvd_next    = dvd_reg;
      quo_next    = quo_reg;
      cnt_next    = cnt_reg;
      active_next = active_reg;
      done_next   = 1'b0;
      if (start || active_reg) begin
         rem_next = ge ? diff[15:0] : partial[15:0];
         dvd_next = {src_dvd[30:0], 1'b0};
         quo_next = {src_quo[30:0], ge};
      end
      if (start) begin
         cnt_next    = 5'd1;
         active_next = 1'b1;
      end else if (active_reg) begin
         cnt_next = cnt_reg + 5'd1;
         if (cnt_reg == 5'd31) begin
            active_next = 1'b0;
            done_next   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (set) begin
         rem_reg    <= '0;
         dvd_reg    <= '0;
         quo_reg    <= '0;
         cnt_reg    <= '0;
         active_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         rem_reg    <= rem_next;
         dvd_reg    <= dvd_next;
         quo_reg    <= quo_next;
         cnt_reg    <= cnt_next;
         active_reg <= active_next;
         done_reg   <= done_next;
      end
   end

   assign done     = done_reg;
   assign quotient = quo_reg;

endmodule

// File: rtl/sonar_distance_filter.sv
// Echo width -> centimetres, range rejection and power-of-two moving average.
// Optional spike rejection is enabled by defining SONAR_FILTER_SPIKE_EN.
module sonar_distance_filter
   import sonar_pkg::*;
#(
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int MAX_CM        = DEF_MAX_CM,
   parameter int AVG_LOG2      = 2,
   parameter int SPIKE_CM      = 50
) (
   input logic                 clk,
   input logic                 set,
   sonar_distance_filter_if.slave bus
);

   localparam int WIN   = 1 << AVG_LOG2;
   localparam int SUM_W = DIST_W + AVG_LOG2;
   localparam int PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WIN - 1);
   localparam logic [RAW_W-1:0] MAX_Q    = RAW_W'(MAX_CM);

   state_t state_reg, state_next;

   logic              div_start;
   logic              div_done;
   logic [RAW_W-1:0]  div_quotient;
   logic              in_range;

   logic              take_sample;
   logic              oor_next;
   logic              dropped_next;
   logic              prime_now;
   logic              spike_reject;

   logic [DIST_W-1:0] sample_reg;
   logic [DIST_W-1:0] hist_reg [WIN];
   logic [PTR_W-1:0]  ptr_reg;
   logic              primed_reg;
   logic [SUM_W-1:0]  sum_reg, sum_next;
   logic [DIST_W-1:0] dist_reg, dist_next;
   logic              dist_valid_reg;
   logic              oor_reg;
   logic              dropped_reg;

   seq_divider_32x16 u_div (
      .clk      (clk),
      .set      (set),
      .start    (div_start),
      .dividend (bus.raw_count),
      .divisor  (16'(CYCLES_PER_CM)),
      .done     (div_done),
      .quotient (div_quotient)
   );

   assign in_range = (div_quotient <= MAX_Q);

`ifdef SONAR_FILTER_SPIKE_EN
   logic [1:0] spike_cnt_reg;
   logic       reprime_reg;
   logic       is_spike;

   assign is_spike     = primed_reg &&
                         (abs_diff16(div_quotient[DIST_W-1:0], dist_reg) > DIST_W'(SPIKE_CM));
   // Three rejections in a row mean the target really moved: the fourth is
   // taken and restarts the average from scratch.
   assign spike_reject = is_spike && (spike_cnt_reg != 2'd3);
   assign prime_now    = !primed_reg || reprime_reg;

   always_ff @(posedge clk) begin
      if (set) begin
         spike_cnt_reg <= 2'd0;
         reprime_reg   <= 1'b0;
      end else if (take_sample) begin
         spike_cnt_reg <= 2'd0;
         reprime_reg   <= is_spike;
      end else if (state_reg == DIVIDE && div_done && in_range && spike_reject) begin
         spike_cnt_reg <= spike_cnt_reg + 2'd1;
      end
   end
`else
   assign spike_reject = 1'b0;
   assign prime_now    = !primed_reg;
`endif

   always_ff @(posedge clk) begin
      if (set) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      div_start    = 1'b0;
      take_sample  = 1'b0;
      oor_next     = 1'b0;
      dropped_next = bus.raw_valid && (state_reg != IDLE);
      unique case (state_reg)
         IDLE: begin
            if (bus.raw_valid) begin
               if (bus.raw_count == '0) begin
                  oor_next = 1'b1;
               end else begin
                  div_start  = 1'b1;
                  state_next = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            if (div_done) begin
               if (!in_range || spike_reject) begin
                  oor_next   = 1'b1;
                  state_next = IDLE;
               end else begin
                  take_sample = 1'b1;
                  state_next  = FILTER;
               end
            end
         end
         FILTER: state_next = OUTPUT;
         OUTPUT: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Running sum: priming fills every slot, otherwise the evicted entry is swapped out.
   always_comb begin
      if (prime_now) begin
         sum_next = SUM_W'(sample_reg) << AVG_LOG2;
      end else begin
         sum_next = sum_reg - SUM_W'(hist_reg[ptr_reg]) + SUM_W'(sample_reg);
      end
      dist_next = DIST_W'(sum_next >> AVG_LOG2);
   end

   generate
      for (genvar gi = 0; gi < WIN; gi++) begin : g_hist
         always_ff @(posedge clk) begin
            if (set) begin
               hist_reg[gi] <= '0;
            end else if (state_reg == FILTER && (prime_now || ptr_reg == PTR_W'(gi))) begin
               hist_reg[gi] <= sample_reg;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (set) begin
         sample_reg     <= '0;
         ptr_reg        <= '0;
         primed_reg     <= 1'b0;
         sum_reg        <= '0;
         dist_reg       <= '0;
         dist_valid_reg <= 1'b0;
         oor_reg        <= 1'b0;
         dropped_reg    <= 1'b0;
      end else begin
         oor_reg        <= oor_next;
         dropped_reg    <= dropped_next;
         dist_valid_reg <= (state_reg == FILTER);
         if (take_sample) begin
            sample_reg <= div_quotient[DIST_W-1:0];
         end
         if (state_reg == FILTER) begin
            sum_reg    <= sum_next;
            dist_reg   <= dist_next;
            primed_reg <= 1'b1;
            if (prime_now || ptr_reg == PTR_LAST) begin
               ptr_reg <= '0;
            end else begin
               ptr_reg <= ptr_reg + PTR_W'(1);
            end
         end
      end
   end

   assign bus.busy         = (state_reg != IDLE);
   assign bus.dist_valid   = dist_valid_reg;
   assign bus.dist_cm      = dist_reg;
   assign bus.out_of_range = oor_reg;
   assign bus.dropped      = dropped_reg;

endmodule

// File: doc/sonar_distance_filter.md
Name: sonar_distance_filter

Overview:
- Sits directly downstream of the ultrasonic sonar echo-timing stage.
- Consumes the raw echo pulse width, in clk cycles, one sample per strobe.
- Converts it to centimetres with a sequential divider, rejects out-of-range readings, and smooths valid readings with a power-of-two moving average.
- Delivers a filtered distance with a one-cycle valid strobe to the navigation/control logic.

Parameters:
- CYCLES_PER_CM, 2900, clk cycles of echo per cm (50 MHz × 58 us/cm); 16-bit, must be nonzero.
- MAX_CM, 400, largest accepted distance in cm; larger quotients are out of range.
- AVG_LOG2, 2, log2 of moving-average window (window = 4 samples); legal 0..4.
- SPIKE_CM, 50, spike threshold in cm (used only with the optional feature).

Ports:
- clk  in  1  system clock
- set  in  1  synchronous active-high reset
- raw_valid  in  1  one-cycle strobe: raw_count holds a new echo width
- raw_count  in  32  echo high time in clk cycles
- busy  out  1  high while a sample is being processed (state != IDLE)
- dist_valid  out  1  one-cycle strobe: dist_cm updated
- dist_cm  out  16  filtered distance in cm, held between strobes
- out_of_range  out  1  one-cycle strobe: sample rejected (zero or > MAX_CM)
- dropped  out  1  one-cycle strobe: raw_valid arrived while busy, sample discarded

Behaviour:
- Clock and reset: one clock `clk`; `set` is a synchronous, active-high reset.
- Reset values: all outputs 0, state IDLE, history cleared, primed = 0.
- States: IDLE, DIVIDE, FILTER, OUTPUT.
- IDLE, raw_valid = 1 at edge t:
  - Latch raw_count.
  - If raw_count == 0: pulse out_of_range in cycle t+1 and stay IDLE.
  - Otherwise go to DIVIDE.
- DIVIDE:
  - Restoring divide, 32-bit dividend by 16-bit CYCLES_PER_CM, one quotient bit per cycle, 32 cycles.
  - Quotient truncated toward zero.
  - If quotient > MAX_CM: pulse out_of_range and return to IDLE. History and dist_cm are unchanged.
  - Otherwise go to FILTER.
- FILTER:
  - If primed = 0: all 2^AVG_LOG2 history entries are loaded with the sample and primed is set.
  - Otherwise the oldest entry is replaced (circular pointer, wraps mod window).
  - Running sum is kept at width 16+AVG_LOG2: add new, subtract evicted.
- OUTPUT (one cycle):
  - dist_cm = sum >> AVG_LOG2, truncating.
  - dist_valid = 1.
  - Next state IDLE.
- Latency: dist_valid is high in the 34th cycle after the edge that sampled raw_valid.
- Throughput: at most one sample per 35 cycles.
- busy is high from cycle t+1 through the OUTPUT cycle inclusive.
- raw_valid while busy (including OUTPUT): sample discarded, dropped pulses the next cycle, processing continues.
- set mid-operation: overrides everything. Division is abandoned, history is unprimed, and no strobe is emitted.
- raw_valid coincident with set is ignored.

Optional Feature:
- Macro: SONAR_FILTER_SPIKE_EN.
- Defined, after priming:
  - A valid quotient whose absolute difference from the current dist_cm exceeds SPIKE_CM is rejected.
  - Rejection pulses out_of_range; no dist_valid; history unchanged.
  - A 2-bit consecutive-reject counter runs. The 4th consecutive spike is accepted and re-primes the history with that sample.
  - Any accepted sample clears the counter.
- Undefined: no spike check; the counter logic is absent.

Decomposition:
- Shared package sonar_pkg:
  - state enum {IDLE, DIVIDE, FILTER, OUTPUT}
  - localparams for the default CYCLES_PER_CM (2900), MAX_CM (400), and raw count width (32); also used by the echo-timing stage.
- Sub-module seq_divider_32x16:
  - Ports: start/done handshake, dividend[31:0], divisor[15:0], quotient[31:0].
  - Fixed 32-cycle latency; shares clk/set.

Test Plan:
1. After reset, raw_count = 290000 → dist_valid 34 cycles later, dist_cm = 100; busy high for 34 cycles.
2. Then raw_count = 145000 (50 cm) → dist_cm = (3×100+50)/4 = 87. Then three more 145000 samples → 75, 62, 50.
3. raw_count = 0 → out_of_range pulse next cycle, no dist_valid, dist_cm holds. raw_count = 2000000 (689 cm) → out_of_range after divide, dist_cm holds.
4. raw_valid at t and again at t+10 → one dist_valid; dropped pulses at t+11. raw_valid in the OUTPUT cycle → dropped.
5. set asserted at t+15 during DIVIDE → all outputs 0 next cycle, no dist_valid. Next sample 290000 re-primes → dist_cm = 100.
6. With SONAR_FILTER_SPIKE_EN: primed at 100 cm, then 87000 (30 cm) ×4 → three out_of_range pulses, 4th gives dist_cm = 30. Without the macro, the first 30 cm sample gives dist_cm = 82.
